// File: rtl/lane_arb_pkg.sv
// Shared types and constants for the lane arbiter: FSM state type, requester count,
// default lane width and burst limit, and burst counter width.
package lane_arb_pkg;

    typedef enum logic [0:0] {
        IDLE,
        GRANT
    } state_e;

    localparam int unsigned NREQ        = 4;
    localparam int unsigned DefW        = 2;
    localparam int unsigned DefMaxBurst = 4;
    localparam int unsigned CntW        = 4;

endpackage

// File: rtl/lane_arb_if.sv
// Request/data/grant bundle between requesters (master) and the lane arbiter (slave).
interface lane_arb_if #(
    parameter int unsigned W    = 2,
    parameter int unsigned NREQ = 4
) ();

    logic                en;
    logic [NREQ-1:0]     req;
    logic [NREQ*W-1:0]   x;
    logic [NREQ-1:0]     gnt;
    logic [1:0]          sel;
    logic [W-1:0]        y;
    logic                y_valid;
    logic                busy;

    modport master (
        output en, req, x,
        input  gnt, sel, y, y_valid, busy
    );

    modport slave (
        input  en, req, x,
        output gnt, sel, y, y_valid, busy
    );

endinterface

// File: rtl/rr_pick.sv
// Round-robin search: first set bit of req starting at ptr and wrapping 3 -> 0.
module rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] ptr,
    output logic       found,
    output logic [1:0] idx
);

    logic [1:0] cand;

    // Walk offsets from farthest to nearest so the nearest hit is the one that sticks.
    always_comb begin
        found = 1'b0;
        idx   = ptr;
        cand  = ptr;
        for (int i = 3; i >= 0; i--) begin
            cand = ptr + 2'(i);
            if (req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/lane_arb.sv
// Round-robin lane arbiter: grants one requester for up to MAXBURST back-to-back transfers,
// registering the granted lane onto y with a one-cycle y_valid strobe per transfer.
module lane_arb
    import lane_arb_pkg::*;
#(
    parameter int unsigned W        = DefW,
    parameter int unsigned NREQ     = lane_arb_pkg::NREQ,
    parameter int unsigned MAXBURST = DefMaxBurst
) (
    input logic       clk,
    input logic       rst,
    lane_arb_if.slave bus
);

    localparam logic [CntW-1:0] MaxCnt = CntW'(MAXBURST);

    state_e          state_q, state_d;
    logic [1:0]      ptr_q, ptr_d;
    logic [1:0]      sel_q, sel_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [W-1:0]    y_q, y_d;
    logic            yv_q, yv_d;

    logic            granted;
    logic            xfer;
    logic            last_xfer;
    logic            rel;
    logic [1:0]      pick_ptr;
    logic            pick_found;
    logic [1:0]      pick_idx;

    assign granted   = (state_q == GRANT);
    assign xfer      = granted && bus.en && bus.req[sel_q];
    assign last_xfer = xfer && ((cnt_q + CntW'(1)) == MaxCnt);
    assign rel       = granted && (!bus.en || !bus.req[sel_q] || last_xfer);
    // While granted, the search always starts just past the current owner: that is the
    // pointer value a release in this cycle would install.
    assign pick_ptr  = granted ? (sel_q + 2'd1) : ptr_q;

    rr_pick u_rr_pick (
        .req   (bus.req[3:0]),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        yv_d    = 1'b0;

        if (xfer) begin
            y_d   = bus.x[W*sel_q +: W];
            yv_d  = 1'b1;
            cnt_d = cnt_q + CntW'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (bus.en && pick_found) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    cnt_d   = '0;
                end
            end
            GRANT: begin
                if (rel) begin
                    ptr_d = sel_q + 2'd1;
                    cnt_d = '0;
                    if (bus.en && pick_found) begin
                        sel_d = pick_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            yv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            yv_q    <= yv_d;
        end
    end

    assign bus.gnt     = granted ? (NREQ'(1) << sel_q) : '0;
    assign bus.sel     = sel_q;
    assign bus.y       = y_q;
    assign bus.y_valid = yv_q;
    assign bus.busy    = granted;

endmodule

// File: tb/tb_lane_arb.sv
// Bench for lane_arb: a grant-level reference model checked every cycle, plus directed
// scenarios with hand-computed expectations.
module tb_lane_arb;

    localparam int unsigned W    = 2;
    localparam int unsigned MAXB = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    lane_arb_if #(.W(W), .NREQ(4)) bus ();

    lane_arb #(
        .W        (W),
        .NREQ     (4),
        .MAXBURST (MAXB)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: owner is the granted requester or -1 when nobody holds the grant.
    int         m_owner = -1;
    int         m_last  = 0;
    int         m_ptr   = 0;
    int         m_cnt   = 0;
    logic [1:0] m_y     = '0;
    bit         m_yv    = 1'b0;
    bit         m_live  = 1'b0;
    bit         m_done;

    function automatic int rr_search(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_last  = 0;
            m_ptr   = 0;
            m_cnt   = 0;
            m_y     = '0;
            m_yv    = 1'b0;
            m_live  = 1'b1;
        end else if (m_live) begin
            m_yv = 1'b0;
            if (m_owner < 0) begin
                if (bus.en && bus.req != 4'b0000) begin
                    m_owner = rr_search(bus.req, m_ptr);
                    m_cnt   = 0;
                end
            end else begin
                m_done = bus.en && bus.req[m_owner];
                if (m_done) begin
                    m_y  = 2'((bus.x >> (W * m_owner)) & 8'h3);
                    m_yv = 1'b1;
                    m_cnt++;
                end
                if (!m_done || m_cnt == MAXB) begin
                    m_ptr = (m_owner + 1) % 4;
                    m_cnt = 0;
                    if (bus.en && bus.req != 4'b0000) m_owner = rr_search(bus.req, m_ptr);
                    else m_owner = -1;
                end
            end
            if (m_owner >= 0) m_last = m_owner;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("model_gnt", 32'(bus.gnt), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
            chk("model_sel", 32'(bus.sel), 32'(m_last));
            chk("model_busy", 32'(bus.busy), 32'(m_owner >= 0));
            chk("model_y_valid", 32'(bus.y_valid), 32'(m_yv));
            chk("model_y", 32'(bus.y), 32'(m_y));
        end
    end

    // Apply inputs (called at a falling edge), then let exactly one rising edge pass.
    task automatic step(input logic r, input logic e, input logic [3:0] rq, input logic [7:0] xv);
        rst     = r;
        bus.en  = e;
        bus.req = rq;
        bus.x   = xv;
        @(negedge clk);
    endtask

    task automatic chk_reset(input string name);
        chk({name, "_gnt"}, 32'(bus.gnt), 32'd0);
        chk({name, "_sel"}, 32'(bus.sel), 32'd0);
        chk({name, "_y"}, 32'(bus.y), 32'd0);
        chk({name, "_yv"}, 32'(bus.y_valid), 32'd0);
        chk({name, "_busy"}, 32'(bus.busy), 32'd0);
    endtask

    int pulses;

    initial begin
        rst     = 1'b1;
        bus.en  = 1'b0;
        bus.req = '0;
        bus.x   = '0;
        @(negedge clk);
        @(negedge clk);
        chk_reset("reset");

        // Single requester: grant, data one edge later, continuous regrant after each burst.
        step(1'b0, 1'b1, 4'b0001, 8'h01);
        chk("sc1_gnt", 32'(bus.gnt), 32'h1);
        chk("sc1_first_yv", 32'(bus.y_valid), 32'd0);
        step(1'b0, 1'b1, 4'b0001, 8'h01);
        chk("sc1_y", 32'(bus.y), 32'h1);
        chk("sc1_yv", 32'(bus.y_valid), 32'd1);
        pulses = 1;
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, 4'b0001, 8'h01);
            pulses += int'(bus.y_valid);
        end
        chk("sc1_pulses", 32'(pulses), 32'd8);
        chk("sc1_regrant", 32'(bus.gnt), 32'h1);
        step(1'b0, 1'b1, 4'b0000, 8'h01);
        chk("sc1_idle_gnt", 32'(bus.gnt), 32'h0);
        chk("sc1_hold_y", 32'(bus.y), 32'h1);

        // Contention: all four requesting, bursts of four in order 0,1,2,3,0 with no gaps.
        step(1'b1, 1'b0, 4'b0000, 8'h00);
        chk_reset("sc2_reset");
        step(1'b0, 1'b1, 4'b1111, 8'hE4);
        chk("sc2_first_gnt", 32'(bus.gnt), 32'h1);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b1, 4'b1111, 8'hE4);
            chk("sc2_yv", 32'(bus.y_valid), 32'd1);
            chk("sc2_y", 32'(bus.y), 32'((k / 4) % 4));
        end
        chk("sc2_next_gnt", 32'(bus.gnt), 32'h2);

        // Early drop: lane 2 loses its request after two transfers, lane 3 takes over.
        step(1'b1, 1'b0, 4'b0000, 8'h00);
        step(1'b0, 1'b1, 4'b0100, 8'hE0);
        chk("sc3_gnt2", 32'(bus.gnt), 32'h4);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 4'b1100, 8'hE0);
            chk("sc3_yv", 32'(bus.y_valid), 32'd1);
            chk("sc3_y", 32'(bus.y), 32'h2);
        end
        step(1'b0, 1'b1, 4'b1000, 8'hE0);
        chk("sc3_drop_yv", 32'(bus.y_valid), 32'd0);
        chk("sc3_gnt3", 32'(bus.gnt), 32'h8);
        step(1'b0, 1'b1, 4'b1000, 8'hE0);
        chk("sc3_y3", 32'(bus.y), 32'h3);

        // Wrap: leave ptr at 3, then req=0101 grants lane 0 first and lane 2 next.
        step(1'b0, 1'b1, 4'b0000, 8'hE0);
        chk("sc4_idle_busy", 32'(bus.busy), 32'd0);
        step(1'b0, 1'b1, 4'b0100, 8'hE0);
        step(1'b0, 1'b1, 4'b0000, 8'hE0);
        chk("sc4_idle_sel", 32'(bus.sel), 32'h2);
        step(1'b0, 1'b1, 4'b0101, 8'h21);
        chk("sc4_gnt0", 32'(bus.gnt), 32'h1);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 4'b0101, 8'h21);
            chk("sc4_y0", 32'(bus.y), 32'h1);
        end
        chk("sc4_gnt2", 32'(bus.gnt), 32'h4);
        step(1'b0, 1'b1, 4'b0101, 8'h21);
        chk("sc4_y2", 32'(bus.y), 32'h2);

        // en low mid-burst: no transfer on that edge, back to idle, then lane 1 wins.
        step(1'b1, 1'b0, 4'b0000, 8'h00);
        step(1'b0, 1'b1, 4'b0001, 8'h21);
        step(1'b0, 1'b1, 4'b0001, 8'h21);
        chk("sc5_t1_yv", 32'(bus.y_valid), 32'd1);
        step(1'b0, 1'b0, 4'b0001, 8'h21);
        chk("sc5_en_yv", 32'(bus.y_valid), 32'd0);
        chk("sc5_en_gnt", 32'(bus.gnt), 32'h0);
        step(1'b0, 1'b1, 4'b0010, 8'h04);
        chk("sc5_gnt1", 32'(bus.gnt), 32'h2);

        // Reset mid-burst: burst discarded, ptr back to 0, req=1010 then grants lane 1.
        step(1'b0, 1'b1, 4'b0010, 8'h04);
        step(1'b0, 1'b1, 4'b0010, 8'h04);
        step(1'b1, 1'b1, 4'b0010, 8'h04);
        chk_reset("sc6_reset");
        step(1'b0, 1'b1, 4'b1010, 8'h44);
        chk("sc6_gnt1", 32'(bus.gnt), 32'h2);
        chk("sc6_no_yv", 32'(bus.y_valid), 32'd0);
        step(1'b0, 1'b1, 4'b1010, 8'h44);
        chk("sc6_y", 32'(bus.y), 32'h1);
        chk("sc6_yv", 32'(bus.y_valid), 32'd1);

        step(1'b0, 1'b0, 4'b0000, 8'h00);
        step(1'b0, 1'b0, 4'b0000, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
